// File: rtl/mem_ctrl_pkg.sv
// Shared constants for mem_ctrl: MMIO decode, register selects, STATUS bit positions and UART
// state encoding.
package mem_ctrl_pkg;

    localparam int unsigned MMIO_SEL_BIT = 47;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLES = 2'd2;

    localparam int unsigned FULL = 0;
    localparam int unsigned BUSY = 1;
    localparam int unsigned OVF  = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a byte FIFO with a sticky overflow flag.
module uart_tx_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       ovf_clr_i,
    output logic       full_o,
    output logic       busy_o,
    output logic       overflow_o,
    output logic       uart_tx_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]   DEPTH_CNT  = FIFO_DEPTH[PW:0];
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          overflow_q;

    uart_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;

    logic push_ok, pop, empty, timer_done;

    assign full_o     = (count_q == DEPTH_CNT);
    assign empty      = (count_q == '0);
    // Fullness uses the pre-edge count, so a push into a full FIFO drops even if a pop coincides.
    assign push_ok    = push_i && !full_o;
    assign timer_done = (timer_q == TIMER_LAST);
    assign busy_o     = (state_q != IDLE);
    assign overflow_o = overflow_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && full_o) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // uart_tx is decoded from state so an asynchronous reset forces the line idle immediately.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        uart_tx_o = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                uart_tx_o = 1'b0;
                if (timer_done) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                uart_tx_o = shift_q[0];
                if (timer_done) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (timer_done) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory/MMIO target: byte-masked 64-bit RAM below bit 47, UART/STATUS/CYCLES registers above.
// Define MEM_CTRL_CYCLE_CNT_EN to build the free-running CYCLES counter.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = 1024,
    parameter string       INIT_FILE    = "",
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] mem_addr,
    inout  wire  [63:0] mem_data,
    input  logic [7:0]  mem_mask,
    input  logic [5:0]  mem_shift,
    input  logic        rw,
    output logic        uart_tx
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [63:0]   ram [RAM_WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    reg_sel;
    logic          is_mmio;
    logic [63:0]   rdata_q, rdata_d;
    logic [63:0]   status, cycles;
    logic          push, ovf_clr, full, busy, overflow;
    logic          unused_bits;

    assign word_idx    = mem_addr[AW+2:3];
    assign reg_sel     = mem_addr[4:3];
    assign is_mmio     = mem_addr[MMIO_SEL_BIT];
    assign unused_bits = ^{mem_shift, mem_addr[MMIO_SEL_BIT-1:AW+3], mem_addr[2:0]};

    always_ff @(posedge clk) begin
        if (rw && !is_mmio) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_mask[i]) begin
                    ram[word_idx][8*i +: 8] <= mem_data[8*i +: 8];
                end
            end
        end
    end

    assign push    = rw && is_mmio && (reg_sel == REG_TXDATA);
    assign ovf_clr = rw && is_mmio && (reg_sel == REG_STATUS) && mem_data[OVF];

`ifdef MEM_CTRL_CYCLE_CNT_EN
    logic [63:0] cycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_q + 64'd1;
        end
    end

    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

    always_comb begin
        status       = '0;
        status[FULL] = full;
        status[BUSY] = busy;
        status[OVF]  = overflow;
    end

    always_comb begin
        rdata_d = '0;
        if (!is_mmio) begin
            rdata_d = ram[word_idx];
        end else begin
            case (reg_sel)
                REG_STATUS: rdata_d = status;
                REG_CYCLES: rdata_d = cycles;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (!rw) begin
            rdata_q <= rdata_d;
        end
    end

    assign mem_data = rw ? {64{1'bz}} : rdata_q;

    uart_tx_fifo #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_data_i(mem_data[7:0]),
        .ovf_clr_i  (ovf_clr),
        .full_o     (full),
        .busy_o     (busy),
        .overflow_o (overflow),
        .uart_tx_o  (uart_tx)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl (RAM_WORDS=1024, FIFO_DEPTH=8, CLKS_PER_BIT=4).
module tb_mem_ctrl;

    localparam logic [47:0] A_TXDATA = 48'h8000_0000_0000;
    localparam logic [47:0] A_STATUS = 48'h8000_0000_0008;
    localparam logic [47:0] A_CYCLES = 48'h8000_0000_0010;
    localparam logic [47:0] A_REG3   = 48'h8000_0000_0018;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] mem_addr;
    logic [63:0] wdata;
    logic [7:0]  mem_mask;
    logic [5:0]  mem_shift;
    logic        rw;
    logic        uart_tx;
    wire  [63:0] mem_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rx_q[$];

    assign mem_data = rw ? wdata : {64{1'bz}};

    always #5 clk = ~clk;

    mem_ctrl #(
        .RAM_WORDS   (1024),
        .INIT_FILE   (""),
        .FIFO_DEPTH  (8),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_mask (mem_mask),
        .mem_shift(mem_shift),
        .rw       (rw),
        .uart_tx  (uart_tx)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All bus tasks are entered and left on a negedge.
    task automatic bus_write(input logic [47:0] a, input logic [63:0] d, input logic [7:0] m);
        mem_addr = a;
        wdata    = d;
        mem_mask = m;
        rw       = 1'b1;
        @(negedge clk);
        rw       = 1'b0;
        mem_mask = 8'h00;
    endtask

    task automatic bus_read(input logic [47:0] a, output logic [63:0] d);
        mem_addr = a;
        rw       = 1'b0;
        @(negedge clk);
        d = mem_data;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 50 && uart_tx !== 1'b0; i++) @(negedge clk);
        check_eq("start_seen", {63'd0, uart_tx}, 64'd0);
    endtask

    // Independent receiver: samples mid-bit, CLKS_PER_BIT=4.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0 && reset === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        logic [63:0] rd, c1, c2;
        logic        exp_bit;
        logic [7:0]  frame_byte;

        reset     = 1'b1;
        rw        = 1'b0;
        mem_addr  = '0;
        wdata     = '0;
        mem_mask  = '0;
        mem_shift = '0;
        frame_byte = 8'h55;
        repeat (3) @(negedge clk);
        check_eq("rst_uart_tx", {63'd0, uart_tx}, 64'd1);
        check_eq("rst_rdata", mem_data, 64'd0);
        reset = 1'b0;
        bus_read(A_STATUS, rd);
        check_eq("rst_status", rd, 64'd0);

        // RAM byte masking and aliasing
        bus_write(48'h100, 64'h1122_3344_5566_7788, 8'hFF);
        bus_write(48'h100, 64'h0000_0000_0000_00AA, 8'h01);
        bus_read(48'h100, rd);
        check_eq("ram_mask01", rd, 64'h1122_3344_5566_77AA);
        bus_write(48'h108, 64'h0123_4567_89AB_CDEF, 8'hFF);
        bus_write(48'h108, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        bus_read(48'h108, rd);
        check_eq("ram_mask00", rd, 64'h0123_4567_89AB_CDEF);
        bus_write(48'h108, 64'hAA00_0000_0000_00BB, 8'h81);
        bus_read(48'h108, rd);
        check_eq("ram_mask81", rd, 64'hAA23_4567_89AB_CDBB);
        bus_write(48'h2000, 64'hDEAD, 8'hFF);
        bus_read(48'h0, rd);
        check_eq("ram_alias", rd, 64'hDEAD);
        bus_read(48'h4000_0000_0000, rd);
        check_eq("ram_alias_hi", rd, 64'hDEAD);
        bus_read(48'h100, rd);
        check_eq("ram_keep", rd, 64'h1122_3344_5566_77AA);

        bus_read(A_REG3, rd);
        check_eq("reg3_read", rd, 64'd0);
        bus_read(A_TXDATA, rd);
        check_eq("txdata_read", rd, 64'd0);

        // Single UART frame, checked cycle by cycle
        bus_write(A_TXDATA, {56'd0, frame_byte}, 8'h00);
        mem_addr = A_STATUS;
        wait_start();
        for (int k = 0; k < 40; k++) begin
            if (k < 4) exp_bit = 1'b0;
            else if (k < 36) exp_bit = frame_byte[(k - 4) / 4];
            else exp_bit = 1'b1;
            check_eq($sformatf("frame_tx[%0d]", k), {63'd0, uart_tx}, {63'd0, exp_bit});
            if (k % 4 == 2) check_eq($sformatf("frame_busy[%0d]", k), {63'd0, mem_data[1]}, 64'd1);
            @(negedge clk);
        end
        check_eq("rx_count_1", rx_q.size(), 64'd1);
        for (int i = 0; i < rx_q.size(); i++) check_eq("rx_55", {56'd0, rx_q[i]}, 64'h55);
        rx_q.delete();
        repeat (4) @(negedge clk);

        // Overflow: 10 back-to-back pushes, one drains at the second edge, the tenth drops
        for (int i = 0; i < 10; i++) bus_write(A_TXDATA, 64'h10 + 64'(i), 8'h00);
        bus_read(A_STATUS, rd);
        check_eq("ovf_status", rd, 64'h7);
        bus_write(A_STATUS, 64'h4, 8'h00);
        bus_read(A_STATUS, rd);
        check_eq("ovf_cleared", rd, 64'h3);
        for (int i = 0; i < 700 && rx_q.size() < 9; i++) @(negedge clk);
        check_eq("rx_count_9", rx_q.size(), 64'd9);
        for (int i = 0; i < rx_q.size(); i++) begin
            check_eq($sformatf("rx_byte[%0d]", i), {56'd0, rx_q[i]}, 64'h10 + 64'(i));
        end
        repeat (4) @(negedge clk);
        bus_read(A_STATUS, rd);
        check_eq("idle_status", rd, 64'd0);

        // Cycle counter
        bus_read(A_CYCLES, c1);
        repeat (9) @(negedge clk);
        bus_read(A_CYCLES, c2);
`ifdef MEM_CTRL_CYCLE_CNT_EN
        check_eq("cycles_diff", c2 - c1, 64'd10);
`else
        check_eq("cycles_off_1", c1, 64'd0);
        check_eq("cycles_off_2", c2, 64'd0);
`endif

        // Reset during data bit 3 with a second byte still queued
        bus_write(A_TXDATA, 64'h00, 8'h00);
        bus_write(A_TXDATA, 64'hA5, 8'h00);
        wait_start();
        repeat (17) @(negedge clk);
        check_eq("pre_rst_tx", {63'd0, uart_tx}, 64'd0);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_tx", {63'd0, uart_tx}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_STATUS, rd);
        check_eq("post_rst_status", rd, 64'd0);
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge clk);
            check_eq($sformatf("post_rst_tx[%0d]", i), {63'd0, uart_tx}, 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
